// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : reg_scoreboard
//  Description : Hazard scoreboard for a 15-entry register file (ids 0x0-0xE,
//                id 0xF means "no register"). Keeps a saturating pending-write
//                count per register between decode and writeback. Decode is
//                held off while a source still has an outstanding writer or a
//                destination counter is full.
//  Ports       : clk_i, rst_n (async, active-low)
//                issue_valid/srcA/srcB/dstE/dstM -> issue_ready
//                ret_validA/ret_dstA, ret_validB/ret_dstB (writeback commits)
//                flush_i (squash all in-flight writers)
//                pending_o[14:0], busy_o, err_o (sticky retire-underflow)
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        issue_valid,
    input  logic [3:0]  issue_srcA,
    input  logic [3:0]  issue_srcB,
    input  logic [3:0]  issue_dstE,
    input  logic [3:0]  issue_dstM,
    output logic        issue_ready,
    input  logic        ret_validA,
    input  logic [3:0]  ret_dstA,
    input  logic        ret_validB,
    input  logic [3:0]  ret_dstB,
    input  logic        flush_i,
    output logic [14:0] pending_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam int               c_NREG = 15;
    localparam logic [CNT_W-1:0] c_MAX  = '1;
    localparam logic [CNT_W-1:0] c_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0]  r_cnt     [c_NREG];
    // Counts padded with a permanently-zero slot 15 so id 0xF can index the
    // table directly: a zero count is never "pending" and never equals MAX,
    // so 0xF never produces a hazard.
    logic [CNT_W-1:0]  w_cnt_ext [16];
    logic              w_accept;
    logic [c_NREG-1:0] w_inc;
    logic [c_NREG-1:0] w_dec;
    logic [c_NREG-1:0] w_uflow;
    logic              r_err;

    assign w_cnt_ext[15] = '0;

    // Hazard decision uses registered counts only; a retire in this cycle
    // does not release a stalled source until the next cycle.
    assign issue_ready = (w_cnt_ext[issue_srcA] == '0)
                       & (w_cnt_ext[issue_srcB] == '0)
                       & (w_cnt_ext[issue_dstE] != c_MAX)
                       & (w_cnt_ext[issue_dstM] != c_MAX);

    assign w_accept = issue_valid & issue_ready;

    genvar r;
    generate
        for (r = 0; r < c_NREG; r++) begin : g_reg
            localparam logic [3:0] c_ID = 4'(r);

            assign w_cnt_ext[r] = r_cnt[r];

            // Equality against a real id makes dstE==dstM (or A==B) collapse
            // into a single increment (decrement) naturally.
            assign w_inc[r] = w_accept & ((issue_dstE == c_ID) | (issue_dstM == c_ID));
            assign w_dec[r] = (ret_validA & (ret_dstA == c_ID))
                            | (ret_validB & (ret_dstB == c_ID));

            // An increment in the same cycle cancels the retire, so only a
            // lone retire on an empty counter is an underflow.
            assign w_uflow[r] = w_dec[r] & ~w_inc[r] & (r_cnt[r] == '0);

            always_ff @(posedge clk_i or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt[r] <= '0;
                end else if (flush_i) begin
                    r_cnt[r] <= '0;
                end else if (w_inc[r] & ~w_dec[r]) begin
                    r_cnt[r] <= r_cnt[r] + c_ONE;
                end else if (w_dec[r] & ~w_inc[r] & (r_cnt[r] != '0)) begin
                    r_cnt[r] <= r_cnt[r] - c_ONE;
                end
            end

            assign pending_o[r] = (r_cnt[r] != '0);
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (!flush_i && (w_uflow != '0)) begin
            r_err <= 1'b1;
        end
    end

    assign busy_o = |pending_o;
    assign err_o  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_scoreboard
//  Description : Self-checking bench for reg_scoreboard: directed cycle table
//                covering stall/release, saturation, same-cycle issue+retire,
//                dual-port same id and flush/sticky error, an asynchronous
//                mid-run reset, then randomized traffic against a count model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_scoreboard;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic [3:0]  issue_srcA, issue_srcB, issue_dstE, issue_dstM;
    logic        issue_ready;
    logic        ret_validA, ret_validB;
    logic [3:0]  ret_dstA, ret_dstB;
    logic        flush_i;
    logic [14:0] pending_o;
    logic        busy_o;
    logic        err_o;

    int tests  = 0;
    int failed = 0;

    reg_scoreboard #(.CNT_W(2)) dut (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .issue_valid(issue_valid),
        .issue_srcA (issue_srcA),
        .issue_srcB (issue_srcB),
        .issue_dstE (issue_dstE),
        .issue_dstM (issue_dstM),
        .issue_ready(issue_ready),
        .ret_validA (ret_validA),
        .ret_dstA   (ret_dstA),
        .ret_validB (ret_validB),
        .ret_dstB   (ret_dstB),
        .flush_i    (flush_i),
        .pending_o  (pending_o),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        v;
        logic [3:0]  sa, sb, de, dm;
        logic        va;
        logic [3:0]  da;
        logic        vb;
        logic [3:0]  db;
        logic        fl;
        logic        rdy;    // expected issue_ready this cycle
        logic [14:0] pend;   // expected pending_o this cycle (before the edge)
        logic        err;    // expected err_o this cycle
    } vec_t;

    localparam int NV = 21;
    vec_t tbl [NV];

    // Reference model: plain integer counts per register.
    int model_cnt [15];
    bit model_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t x);
        issue_valid = x.v;
        issue_srcA  = x.sa;
        issue_srcB  = x.sb;
        issue_dstE  = x.de;
        issue_dstM  = x.dm;
        ret_validA  = x.va;
        ret_dstA    = x.da;
        ret_validB  = x.vb;
        ret_dstB    = x.db;
        flush_i     = x.fl;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        issue_srcA  = 4'hF;
        issue_srcB  = 4'hF;
        issue_dstE  = 4'hF;
        issue_dstM  = 4'hF;
        ret_validA  = 1'b0;
        ret_dstA    = 4'hF;
        ret_validB  = 1'b0;
        ret_dstB    = 4'hF;
        flush_i     = 1'b0;
    endtask

    function automatic bit model_ready();
        if (issue_srcA != 4'hF && model_cnt[issue_srcA] != 0) return 1'b0;
        if (issue_srcB != 4'hF && model_cnt[issue_srcB] != 0) return 1'b0;
        if (issue_dstE != 4'hF && model_cnt[issue_dstE] == 3) return 1'b0;
        if (issue_dstM != 4'hF && model_cnt[issue_dstM] == 3) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [14:0] model_pending();
        logic [14:0] p = '0;
        for (int i = 0; i < 15; i++) p[i] = (model_cnt[i] != 0);
        return p;
    endfunction

    // Applies one clock edge worth of the rules to the model.
    task automatic model_step(input bit rdy);
        int add [15];
        int sub [15];
        int n;
        if (flush_i) begin
            for (int i = 0; i < 15; i++) model_cnt[i] = 0;
            return;
        end
        for (int i = 0; i < 15; i++) begin
            add[i] = 0;
            sub[i] = 0;
        end
        if (issue_valid && rdy) begin
            if (issue_dstE != 4'hF) add[issue_dstE] = 1;
            if (issue_dstM != 4'hF) add[issue_dstM] = 1;
        end
        if (ret_validA && ret_dstA != 4'hF) sub[ret_dstA] = 1;
        if (ret_validB && ret_dstB != 4'hF) sub[ret_dstB] = 1;
        for (int i = 0; i < 15; i++) begin
            n = model_cnt[i] + add[i] - sub[i];
            if (n < 0) begin
                model_err = 1'b1;
                n = 0;
            end
            model_cnt[i] = n;
        end
    endtask

    function automatic logic [3:0] rid();
        int k = $urandom_range(0, 5);
        return (k == 5) ? 4'hF : 4'(k);
    endfunction

    initial begin
        //        v  sa    sb    de    dm    va da    vb db    fl  rdy pend      err
        tbl[0]  = '{1, 4'hF, 4'hF, 4'hF, 4'hF, 0, 4'hF, 0, 4'hF, 0, 1, 15'h0000, 0}; // all-F ids
        tbl[1]  = '{1, 4'hF, 4'hF, 4'h3, 4'hF, 0, 4'hF, 0, 4'hF, 0, 1, 15'h0000, 0}; // write r3
        tbl[2]  = '{1, 4'h3, 4'hF, 4'hF, 4'hF, 1, 4'h3, 0, 4'hF, 0, 0, 15'h0008, 0}; // RAW stall, r3 retires
        tbl[3]  = '{1, 4'h3, 4'hF, 4'hF, 4'hF, 0, 4'hF, 0, 4'hF, 0, 1, 15'h0000, 0}; // released next cycle
        tbl[4]  = '{1, 4'hF, 4'hF, 4'h5, 4'hF, 0, 4'hF, 0, 4'hF, 0, 1, 15'h0000, 0}; // r5 -> 1
        tbl[5]  = '{1, 4'hF, 4'hF, 4'h5, 4'hF, 0, 4'hF, 0, 4'hF, 0, 1, 15'h0020, 0}; // r5 -> 2
        tbl[6]  = '{1, 4'hF, 4'hF, 4'h5, 4'hF, 0, 4'hF, 0, 4'hF, 0, 1, 15'h0020, 0}; // r5 -> 3
        tbl[7]  = '{1, 4'hF, 4'hF, 4'h5, 4'hF, 1, 4'h5, 0, 4'hF, 0, 0, 15'h0020, 0}; // full; retire -> 2
        tbl[8]  = '{1, 4'hF, 4'hF, 4'h5, 4'hF, 0, 4'hF, 0, 4'hF, 0, 1, 15'h0020, 0}; // 4th accepted -> 3
        tbl[9]  = '{1, 4'hF, 4'hF, 4'h5, 4'hF, 0, 4'hF, 0, 4'hF, 1, 0, 15'h0020, 0}; // still full; flush
        tbl[10] = '{1, 4'hF, 4'hF, 4'h2, 4'hF, 0, 4'hF, 0, 4'hF, 0, 1, 15'h0000, 0}; // r2 -> 1
        tbl[11] = '{1, 4'hF, 4'hF, 4'h2, 4'hF, 1, 4'h2, 0, 4'hF, 0, 1, 15'h0004, 0}; // +1 -1 same cycle
        tbl[12] = '{0, 4'hF, 4'hF, 4'hF, 4'hF, 1, 4'h2, 0, 4'hF, 0, 1, 15'h0004, 0}; // r2 -> 0
        tbl[13] = '{1, 4'hF, 4'hF, 4'h7, 4'h7, 0, 4'hF, 0, 4'hF, 0, 1, 15'h0000, 0}; // dstE=dstM=7 -> 1
        tbl[14] = '{0, 4'hF, 4'hF, 4'hF, 4'hF, 1, 4'h7, 1, 4'h7, 0, 1, 15'h0080, 0}; // A=B=7 -> 0
        tbl[15] = '{1, 4'hF, 4'hF, 4'h1, 4'h4, 0, 4'hF, 0, 4'hF, 0, 1, 15'h0000, 0}; // r1,r4
        tbl[16] = '{1, 4'hF, 4'hF, 4'h9, 4'hF, 0, 4'hF, 0, 4'hF, 0, 1, 15'h0012, 0}; // r9
        tbl[17] = '{1, 4'hF, 4'hF, 4'h9, 4'hF, 1, 4'h4, 0, 4'hF, 1, 1, 15'h0212, 0}; // flush wins
        tbl[18] = '{0, 4'hF, 4'hF, 4'hF, 4'hF, 1, 4'h4, 0, 4'hF, 0, 1, 15'h0000, 0}; // underflow r4
        tbl[19] = '{0, 4'hF, 4'hF, 4'hF, 4'hF, 0, 4'hF, 0, 4'hF, 0, 1, 15'h0000, 1}; // err set
        tbl[20] = '{0, 4'hF, 4'hF, 4'hF, 4'hF, 0, 4'hF, 0, 4'hF, 0, 1, 15'h0000, 1}; // err sticky

        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        chk("reset_pending", 32'(pending_o), 32'h0);
        chk("reset_busy",    32'(busy_o),    32'h0);
        chk("reset_err",     32'(err_o),     32'h0);
        chk("reset_ready",   32'(issue_ready), 32'h1);
        rst_n = 1'b1;

        // Directed cycle table
        for (int i = 0; i < NV; i++) begin
            @(negedge clk_i);
            drive(tbl[i]);
            #1;
            chk($sformatf("tbl%0d_ready", i),   32'(issue_ready), 32'(tbl[i].rdy));
            chk($sformatf("tbl%0d_pending", i), 32'(pending_o),   32'(tbl[i].pend));
            chk($sformatf("tbl%0d_busy", i),    32'(busy_o),      32'(tbl[i].pend != 0));
            chk($sformatf("tbl%0d_err", i),     32'(err_o),       32'(tbl[i].err));
        end

        // Mid-run asynchronous reset: build some pending state, then clear
        // it between clock edges.
        @(negedge clk_i);
        idle();
        issue_valid = 1'b1;
        issue_dstE  = 4'h6;
        issue_dstM  = 4'hA;
        @(negedge clk_i);
        idle();
        #1;
        chk("pre_reset_pending", 32'(pending_o), 32'h0440);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_pending", 32'(pending_o), 32'h0);
        chk("async_reset_busy",    32'(busy_o),    32'h0);
        chk("async_reset_err",     32'(err_o),     32'h0);
        @(negedge clk_i);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) model_cnt[i] = 0;
        model_err = 1'b0;

        // Randomized traffic against the count model
        for (int c = 0; c < 400; c++) begin
            bit mr;
            @(negedge clk_i);
            issue_valid = ($urandom_range(0, 3) != 0);
            issue_srcA  = rid();
            issue_srcB  = rid();
            issue_dstE  = rid();
            issue_dstM  = rid();
            ret_dstA    = rid();
            ret_dstB    = rid();
            // Mostly retire registers that really have writers outstanding.
            ret_validA  = (ret_dstA != 4'hF && model_cnt[ret_dstA] != 0) ? ($urandom_range(0, 1) == 1)
                                                                         : ($urandom_range(0, 30) == 0);
            ret_validB  = (ret_dstB != 4'hF && model_cnt[ret_dstB] != 0) ? ($urandom_range(0, 1) == 1)
                                                                         : ($urandom_range(0, 30) == 0);
            flush_i     = ($urandom_range(0, 40) == 0);
            #1;
            mr = model_ready();
            chk("rnd_ready",   32'(issue_ready), 32'(mr));
            chk("rnd_pending", 32'(pending_o),   32'(model_pending()));
            chk("rnd_busy",    32'(busy_o),      32'(model_pending() != 0));
            chk("rnd_err",     32'(err_o),       32'(model_err));
            model_step(mr);
        end

        @(negedge clk_i);
        idle();
        #1;
        chk("final_pending", 32'(pending_o), 32'(model_pending()));
        chk("final_err",     32'(err_o),     32'(model_err));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
